program_loader: RTL

Boot-time program loader that writes the instruction image into CPU memory through the memory's data write port, while the CPU's instruction fetch reads the same memory. It consumes a byte stream with a valid/ready handshake, assembles big-endian 32-bit words, writes them to consecutive word addresses, and holds the CPU in reset until the image is fully loaded. It sits between the off-chip byte source (UART/testbench) and the memory's `data_in`/`data_addr`/`wr_en` inputs.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_byte_assembler.sv | 46 ++++
 rtl/program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// word geometry and the instruction-word address helper.
package program_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // Byte address of instruction word number idx; 32-bit wrap-around.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx * 32'(BYTES_PER_WORD));
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word assembler. Accepted bytes shift in MSB first; the
// completed word and word_done are presented combinationally during the
// accept of the 4th byte so the FSM can act on the same clock edge.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_i,
    input  logic        accept_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      shift_q, shift_d;

    // Next-state for the byte counter and the three-byte history register.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_o      = {shift_q, byte_i};
        word_done_o = accept_i && (cnt_q == LAST_BYTE);
        if (accept_i) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    // Assembler registers; synchronous reset wins over a simultaneous accept.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a big-endian byte stream (word count N,
// then N words), writes the words to consecutive memory words starting at
// base_addr and holds the CPU in reset until the image is loaded.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN -- when defined, a 32-bit
// wrap-around sum of all data words follows the image and must match.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] base_addr = 32'h0,
    parameter int unsigned max_words = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS_W = 32'(max_words);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = ST_CHK;
`else
    localparam state_e AFTER_DATA = ST_DONE;
`endif

    state_e      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;
    logic        byte_ready_q, byte_ready_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        accept;
    logic [31:0] word;
    logic        word_done;

    assign accept = byte_valid && byte_ready_q;

    byte_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .byte_i      (byte_in),
        .accept_i    (accept),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // FSM next state; registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            ST_LEN: begin
                if (word_done) begin
                    len_d = word;
                    if (word == 32'd0)
                        state_d = AFTER_DATA;
                    else if (word > MAX_WORDS_W)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_done) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = word_addr(base_addr, idx_q);
                    wr_data_d = word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + word;
`endif
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_d == len_q) ? AFTER_DATA : ST_LOAD;
            end
            ST_CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (word_done)
                    state_d = (word == sum_q) ? ST_DONE : ST_ERROR;
`endif
            end
            ST_DONE, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_LEN;
            end
        endcase

        byte_ready_d = (state_d == ST_LEN) || (state_d == ST_LOAD) ||
                       (state_d == ST_CHK);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERROR);
        cpu_reset_d  = (state_d != ST_DONE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LEN;
            len_q        <= '0;
            idx_q        <= '0;
            byte_ready_q <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
